// File: rtl/dcache_port_arbiter_pkg.sv
// dcache_port_arbiter_pkg
//   Shared types for the dcache port arbiter: the memory access size
//   encoding, the holding-register request record, the arbiter FSM states,
//   the default load watchdog limit and a small owner-decode helper.
package dcache_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE  = 2'd0,
    MEM_HALF  = 2'd1,
    MEM_WORD  = 2'd2,
    MEM_DWORD = 2'd3
  } mem_size_t;

  // One captured dcache access; data is forced to zero for loads so the
  // store-data bus stays quiet on reads.
  typedef struct packed {
    logic        we;
    mem_size_t   size;
    logic [31:0] addr;
    logic [63:0] data;
  } dcache_req_t;

  localparam int DCACHE_ARB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ST   = 2'd1,
    LD   = 2'd2
  } arb_state_t;

  localparam dcache_req_t HOLD_CLEAR = '{we: 1'b0, size: MEM_BYTE, addr: 32'h0, data: 64'h0};

  // Requester index to one-hot response vector.
  function automatic logic [1:0] owner_onehot(input logic idx);
    if (idx) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin picker. A lone request is granted
//   outright; when both request, ptr selects the winner. The pointer
//   register itself lives in the parent.
// Ports:
//   req   in  [1:0]  request vector
//   ptr   in  1      preferred requester when both request
//   grant out [1:0]  one-hot grant, or zero when nothing requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Resolve contention with the pointer; otherwise pass the request through.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Shares the single core-side dcache port between the INT (port 0) and
//   FP (port 1) load/store pipes. One transaction at a time, round-robin
//   between contenders; a store completes after one issue cycle, a load
//   completes the cycle after the dcache returns data.
// Optional feature: define DCACHE_ARB_TIMEOUT_EN to add a load watchdog that
//   aborts a load (resp_err=1) after TIMEOUT_CYCLES unanswered LD cycles.
// Ports:
//   clock, reset (async, active-low)
//   req_valid/req_we/req_size/req_addr/req_data  per-requester request
//   req_ready   combinational accept strobe, IDLE only
//   resp_valid  one-cycle completion pulse to the owner
//   resp_data   registered load data (0 for stores)
//   resp_err    aborted load (watchdog build only, else 0)
//   core2dcache_*  registered dcache request bus
//   dcache2core_data/_valid  load return from the dcache
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DCACHE_ARB_TIMEOUT_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_we,
  input  mem_size_t [NUM_REQ-1:0]  req_size,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][63:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [63:0]              resp_data,
  output logic                     resp_err,
  output logic                     core2dcache_req,
  output logic [31:0]              core2dcache_addr,
  output logic [63:0]              core2dcache_data,
  output logic                     core2dcache_data_we,
  output mem_size_t                core2dcache_data_size,
  input  logic [63:0]              dcache2core_data,
  input  logic                     dcache2core_data_valid
);

  arb_state_t  state_r;
  logic        rr_ptr_r;
  logic        owner_r;
  logic        busy_r;
  dcache_req_t hold_r;
  logic [1:0]  resp_valid_r;
  logic [63:0] resp_data_r;

  logic [1:0]  grant_s;
  logic        gnt_idx_s;
  dcache_req_t sel_req_s;

`ifdef DCACHE_ARB_TIMEOUT_EN
  localparam int TO_CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_CW-1:0] TO_LIMIT = TO_CW'(TIMEOUT_CYCLES);
  localparam logic [TO_CW-1:0] TO_ONE   = TO_CW'(1);
  logic [TO_CW-1:0] to_cnt_r;
  logic             resp_err_r;
  assign resp_err = resp_err_r;
`else
  // Without the watchdog the limit has no meaning.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign resp_err = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s)
  );

  assign gnt_idx_s = grant_s[1];

  // Accept only in IDLE; the picker output is the ready vector.
  always_comb begin
    req_ready = 2'b00;
    if (state_r == IDLE) begin
      req_ready = grant_s;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Capture the granted request; store data is zeroed for loads.
  always_comb begin
    sel_req_s.we   = req_we[gnt_idx_s];
    sel_req_s.size = req_size[gnt_idx_s];
    sel_req_s.addr = req_addr[gnt_idx_s];
    if (req_we[gnt_idx_s]) begin
      sel_req_s.data = req_data[gnt_idx_s];
    end else begin
      sel_req_s.data = 64'h0;
    end
  end

  // The holding register drives the dcache bus directly; it is cleared
  // whenever the arbiter returns to IDLE so the bus idles at zero.
  assign core2dcache_req       = busy_r;
  assign core2dcache_addr      = hold_r.addr;
  assign core2dcache_data      = hold_r.data;
  assign core2dcache_data_we   = hold_r.we;
  assign core2dcache_data_size = hold_r.size;
  assign resp_valid            = resp_valid_r;
  assign resp_data             = resp_data_r;

  // Arbiter FSM: accept in IDLE, one issue cycle for stores, wait for data
  // (or the watchdog) for loads. Response pulses default low every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      rr_ptr_r     <= 1'b0;
      owner_r      <= 1'b0;
      busy_r       <= 1'b0;
      hold_r       <= HOLD_CLEAR;
      resp_valid_r <= 2'b00;
      resp_data_r  <= 64'h0;
`ifdef DCACHE_ARB_TIMEOUT_EN
      to_cnt_r     <= '0;
      resp_err_r   <= 1'b0;
`endif
    end else begin
      resp_valid_r <= 2'b00;
      resp_data_r  <= 64'h0;
`ifdef DCACHE_ARB_TIMEOUT_EN
      resp_err_r   <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (|grant_s) begin
            hold_r   <= sel_req_s;
            owner_r  <= gnt_idx_s;
            rr_ptr_r <= ~gnt_idx_s;
            busy_r   <= 1'b1;
            state_r  <= sel_req_s.we ? ST : LD;
`ifdef DCACHE_ARB_TIMEOUT_EN
            to_cnt_r <= '0;
`endif
          end
        end
        ST: begin
          resp_valid_r <= owner_onehot(owner_r);
          hold_r       <= HOLD_CLEAR;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        LD: begin
          // Returned data wins over a watchdog expiry in the same cycle.
          if (dcache2core_data_valid) begin
            resp_valid_r <= owner_onehot(owner_r);
            resp_data_r  <= dcache2core_data;
            hold_r       <= HOLD_CLEAR;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
`ifdef DCACHE_ARB_TIMEOUT_EN
          end else if (to_cnt_r == TO_LIMIT) begin
            resp_valid_r <= owner_onehot(owner_r);
            resp_err_r   <= 1'b1;
            hold_r       <= HOLD_CLEAR;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
`endif
          end
        end
        default: begin
          hold_r  <= HOLD_CLEAR;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
